// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operands in, write-back triple, stall and HI/LO out.
// Also holds the operand widths and the ALU opcode encodings shared with decode.
`ifndef EX_STAGE_DEFS
`define EX_STAGE_DEFS
`define Alu_Op 7:0
`define Alu_Sel 2:0
`define Reg 31:0
`define Reg_Addr 4:0
`define EXE_RES_NOP 3'b000
`define EXE_RES_LOGIC 3'b001
`define EXE_RES_MOVE 3'b011
`define EXE_RES_ARITH 3'b100
`define EXE_AND_OP 8'b00100100
`define EXE_OR_OP 8'b00100101
`define EXE_XOR_OP 8'b00100110
`define EXE_NOR_OP 8'b00100111
`define EXE_ADDU_OP 8'b00100001
`define EXE_SUBU_OP 8'b00100011
`define EXE_MFHI_OP 8'b00010000
`define EXE_MFLO_OP 8'b00010010
`define EXE_DIV_OP 8'b00011010
`define EXE_DIVU_OP 8'b00011011
`endif

interface ex_stage_if;
  logic [`Alu_Op] aluop_i;
  logic [`Alu_Sel] alusel_i;
  logic [`Reg] reg1_i;
  logic [`Reg] reg2_i;
  logic [`Reg_Addr] wd_i;
  logic wreg_i;
  logic flush_i;
  logic [`Reg_Addr] wd_o;
  logic wreg_o;
  logic [`Reg] wdata_o;
  logic stallreq_o;
  logic [`Reg] hi_o;
  logic [`Reg] lo_o;
  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input wd_o, wreg_o, wdata_o, stallreq_o, hi_o, lo_o
  );
  modport slave (
    input aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wd_o, wreg_o, wdata_o, stallreq_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: single-cycle ALU/move results, HI/LO registers and a restoring DIV/DIVU engine.
// Define EX_DIV_ZERO_FAST_EN to skip the 32 iterations when the divisor is zero.
module ex_stage #(
  parameter int DIV_STEPS = 32
) (
  input logic clk,
  input logic rst,
  ex_stage_if.slave bus
);
  localparam int CW = $clog2(DIV_STEPS);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, idx;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d, res;
  logic [32:0] rem_sh;
  logic s1_q, s1_d, s2_q, s2_d, is_div, is_sdiv, ge, stall, div0;
  assign is_sdiv = bus.aluop_i == `EXE_DIV_OP;
  assign is_div = is_sdiv || bus.aluop_i == `EXE_DIVU_OP;
  assign idx = CW'(DIV_STEPS - 1) - count_q;
  assign rem_sh = {rem_q, dvd_q[idx]};
  assign ge = rem_sh >= {1'b0, dvs_q};
  assign div0 = dvs_q == '0;
  assign stall = !bus.flush_i && ((state_q == IDLE && is_div) || state_q == BUSY);
  always_comb begin
    res = bus.alusel_i == `EXE_RES_LOGIC ?
            (bus.aluop_i == `EXE_OR_OP  ? bus.reg1_i | bus.reg2_i :
             bus.aluop_i == `EXE_AND_OP ? bus.reg1_i & bus.reg2_i :
             bus.aluop_i == `EXE_XOR_OP ? bus.reg1_i ^ bus.reg2_i :
             bus.aluop_i == `EXE_NOR_OP ? ~(bus.reg1_i | bus.reg2_i) : '0) :
          bus.alusel_i == `EXE_RES_ARITH ?
            (bus.aluop_i == `EXE_ADDU_OP ? bus.reg1_i + bus.reg2_i :
             bus.aluop_i == `EXE_SUBU_OP ? bus.reg1_i - bus.reg2_i : '0) :
          bus.alusel_i == `EXE_RES_MOVE ?
            (bus.aluop_i == `EXE_MFHI_OP ? hi_q :
             bus.aluop_i == `EXE_MFLO_OP ? lo_q : '0) : '0;
  end
  // Outputs are forced quiet while reset is held, independent of the operand bus.
  assign bus.wdata_o = rst ? res : '0;
  assign bus.wd_o = rst ? bus.wd_i : '0;
  assign bus.wreg_o = rst && bus.wreg_i && !is_div;
  assign bus.stallreq_o = rst && stall;
  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d = hi_q;
    lo_d = lo_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (bus.flush_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (is_div) begin
        s1_d = is_sdiv && bus.reg1_i[31];
        s2_d = is_sdiv && bus.reg2_i[31];
        dvd_d = s1_d ? -bus.reg1_i : bus.reg1_i;
        dvs_d = s2_d ? -bus.reg2_i : bus.reg2_i;
        quo_d = '0;
        rem_d = '0;
        count_d = '0;
`ifdef EX_DIV_ZERO_FAST_EN
        state_d = bus.reg2_i == '0 ? DONE : BUSY;
`else
        state_d = BUSY;
`endif
      end
      BUSY: begin
        rem_d = ge ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
        quo_d = {quo_q[30:0], ge};
        count_d = count_q + 1'b1;
        state_d = count_q == CW'(DIV_STEPS - 1) ? DONE : BUSY;
      end
      DONE: begin
        // Divide-by-zero returns the original dividend in HI with no sign fix.
        lo_d = div0 ? '1 : (s1_q ^ s2_q) ? -quo_q : quo_q;
        hi_d = div0 ? (s1_q ? -dvd_q : dvd_q) : s1_q ? -rem_q : rem_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized ALU and divide traffic checked against an arithmetic reference model.
module tb_ex_stage;
  localparam logic [7:0] AND_OP = 8'b00100100, OR_OP = 8'b00100101, XOR_OP = 8'b00100110,
    NOR_OP = 8'b00100111, ADDU_OP = 8'b00100001, SUBU_OP = 8'b00100011, MFHI_OP = 8'b00010000,
    MFLO_OP = 8'b00010010, DIV_OP = 8'b00011010, DIVU_OP = 8'b00011011;
  localparam logic [2:0] RES_NOP = 3'b000, RES_LOGIC = 3'b001, RES_MOVE = 3'b011, RES_ARITH = 3'b100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  ex_stage_if bus();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    case (op)
      AND_OP, OR_OP, XOR_OP, NOR_OP: return RES_LOGIC;
      ADDU_OP, SUBU_OP: return RES_ARITH;
      MFHI_OP, MFLO_OP: return RES_MOVE;
      default: return RES_NOP;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      AND_OP: return a & b;
      OR_OP: return a | b;
      XOR_OP: return a ^ b;
      NOR_OP: return ~(a | b);
      ADDU_OP: return a + b;
      SUBU_OP: return a - b;
      MFHI_OP: return model_hi;
      MFLO_OP: return model_lo;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void div_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
    longint sa, sb;
    if (b == 32'h0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else if (op == DIVU_OP) begin
      l = a / b;
      h = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      l = 32'(sa / sb);
      h = 32'(sa % sb);
    end
  endfunction

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wr);
    bus.aluop_i = op;
    bus.alusel_i = sel_of(op);
    bus.reg1_i = a;
    bus.reg2_i = b;
    bus.wd_i = wd;
    bus.wreg_i = wr;
  endtask

  task automatic check_alu(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] wd;
    wd = 5'($urandom_range(1, 31));
    drive(op, a, b, wd, 1'b1);
    #1;
    checks++;
    if (bus.wdata_o !== alu_ref(op, a, b) || bus.wreg_o !== 1'b1 || bus.wd_o !== wd || bus.stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL %s wdata=%h wreg=%b wd=%0d stall=%b required wdata=%h wreg=1 wd=%0d stall=0",
               name, bus.wdata_o, bus.wreg_o, bus.wd_o, bus.stallreq_o, alu_ref(op, a, b), wd);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    int exp_n;
    logic [31:0] eh, el;
    exp_n = 33;
`ifdef EX_DIV_ZERO_FAST_EN
    if (b == 32'h0) exp_n = 1;
`endif
    drive(op, a, b, 5'd9, 1'b1);
    #1;
    checks++;
    if (bus.wreg_o !== 1'b0 || bus.stallreq_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_start wreg=%b stall=%b required wreg=0 stall=1", name, bus.wreg_o, bus.stallreq_o);
    end
    n = 1;
    while (n < 100) begin
      @(posedge clk); #1;
      if (bus.stallreq_o !== 1'b1) break;
      n++;
    end
    checks++;
    if (n != exp_n) begin
      failures++;
      $display("FAIL %s_stall cycles=%0d required=%0d", name, n, exp_n);
    end
    div_ref(op, a, b, eh, el);
    model_hi = eh;
    model_lo = el;
    @(posedge clk); #1;
    drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    checks++;
    if (bus.hi_o !== model_hi || bus.lo_o !== model_lo) begin
      failures++;
      $display("FAIL %s_hilo hi=%h lo=%h required hi=%h lo=%h", name, bus.hi_o, bus.lo_o, model_hi, model_lo);
    end
  endtask

  task automatic test_reset();
    drive(OR_OP, 32'h1234, 32'hFF, 5'd3, 1'b1);
    bus.flush_i = 1'b0;
    #3;
    checks++;
    if (bus.wreg_o !== 1'b0 || bus.wd_o !== 5'd0 || bus.wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_wb wreg=%b wd=%0d wdata=%h required 0 0 0", bus.wreg_o, bus.wd_o, bus.wdata_o);
    end
    drive(DIVU_OP, 32'd100, 32'd7, 5'd3, 1'b1);
    #1;
    checks++;
    if (bus.stallreq_o !== 1'b0 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_state stall=%b hi=%h lo=%h required 0 0 0", bus.stallreq_o, bus.hi_o, bus.lo_o);
    end
    drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_alu();
    logic [7:0] ops [6];
    ops = '{OR_OP, AND_OP, XOR_OP, NOR_OP, ADDU_OP, SUBU_OP};
    check_alu("ori", OR_OP, 32'h0000_1234, 32'h0000_00FF);
    check_alu("subu_wrap", SUBU_OP, 32'h0, 32'h1);
    check_alu("addu_wrap", ADDU_OP, 32'hFFFF_FFFF, 32'h2);
    for (int i = 0; i < 24; i++) check_alu("alu_rand", ops[$urandom_range(0, 5)], $urandom, $urandom);
  endtask

  task automatic test_nop();
    drive(OR_OP, 32'hDEAD_BEEF, 32'h1, 5'd4, 1'b1);
    bus.alusel_i = RES_NOP;
    #1;
    checks++;
    if (bus.wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL nop wdata=%h required 0", bus.wdata_o);
    end
    bus.alusel_i = 3'b111;
    #1;
    checks++;
    if (bus.wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL unknown_sel wdata=%h required 0", bus.wdata_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    run_div("divu_100_7", DIVU_OP, 32'd100, 32'd7);
    check_alu("mflo", MFLO_OP, $urandom, $urandom);
    check_alu("mfhi", MFHI_OP, $urandom, $urandom);
    run_div("div_m7_2", DIV_OP, 32'hFFFF_FFF9, 32'd2);
    run_div("div_7_m2", DIV_OP, 32'd7, 32'hFFFF_FFFE);
    run_div("divu_5_0", DIVU_OP, 32'd5, 32'd0);
    run_div("div_neg_0", DIV_OP, 32'hFFFF_FF00, 32'd0);
    run_div("div_min_m1", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      run_div("div_rand", (i < 3) ? DIV_OP : DIVU_OP, a, b);
      check_alu("mf_rand", (i % 2 == 0) ? MFLO_OP : MFHI_OP, $urandom, $urandom);
    end
  endtask

  task automatic test_back_to_back();
    run_div("b2b_first", DIVU_OP, $urandom, 32'($urandom_range(1, 50)));
    run_div("b2b_second", DIV_OP, $urandom, $urandom | 32'h1);
    check_alu("b2b_mflo", MFLO_OP, 32'h0, 32'h0);
  endtask

  task automatic test_abort(input logic use_reset);
    drive(DIVU_OP, $urandom, 32'($urandom_range(1, 99)), 5'd7, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    if (use_reset) begin
      rst = 1'b0;
      model_hi = '0;
      model_lo = '0;
    end else bus.flush_i = 1'b1;
    #1;
    checks++;
    if (bus.stallreq_o !== 1'b0 || bus.hi_o !== model_hi || bus.lo_o !== model_lo) begin
      failures++;
      $display("FAIL abort_%0d stall=%b hi=%h lo=%h required stall=0 hi=%h lo=%h",
               use_reset, bus.stallreq_o, bus.hi_o, bus.lo_o, model_hi, model_lo);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.flush_i = 1'b0;
    drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.stallreq_o !== 1'b0 || bus.hi_o !== model_hi || bus.lo_o !== model_lo) begin
      failures++;
      $display("FAIL abort_idle_%0d stall=%b hi=%h lo=%h required stall=0 hi=%h lo=%h",
               use_reset, bus.stallreq_o, bus.hi_o, bus.lo_o, model_hi, model_lo);
    end
    run_div("after_abort", DIVU_OP, $urandom, 32'($urandom_range(1, 999)));
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_alu();
    test_nop();
    test_div();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
